// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   - GAP/SHOW scan state enum
//   - segment lookup table for BCD codes 0..9 (gfedcba, active-high)
//   - blank code used to force a dark digit
//   - width helpers for the slot counter and digit index (minimum 1 bit)
package seg7_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    // Any code >= 10 decodes to no segments; 15 is the one used on purpose.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic int cnt_width(input int slot_cyc);
        return (slot_cyc > 1) ? $clog2(slot_cyc) : 1;
    endfunction

    function automatic int idx_width(input int num_dig);
        return (num_dig > 1) ? $clog2(num_dig) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus of the seven-segment scan driver.
//   digits_in  : packed BCD digits, digit 0 in [3:0] (rightmost)
//   dp_in      : decimal point per digit, 1 = lit
//   upd_stb    : one-cycle strobe capturing digits_in/dp_in
//   seg_out    : [6:0] a..g, [7] dp, [8] always 0, active-high
//   dig_sel    : active-low digit enables, at most one low
//   frame_done : one-cycle pulse at the end of each frame
// master = producer of digits / consumer of pins, slave = scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIG = 4
);
    logic [4*NUM_DIG-1:0] digits_in;
    logic [NUM_DIG-1:0]   dp_in;
    logic                 upd_stb;
    logic [8:0]           seg_out;
    logic [NUM_DIG-1:0]   dig_sel;
    logic                 frame_done;

    modport master (
        output digits_in, dp_in, upd_stb,
        input  seg_out, dig_sel, frame_done
    );

    modport slave (
        input  digits_in, dp_in, upd_stb,
        output seg_out, dig_sel, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder.
//   code : 4-bit digit code; 10..15 give blank segments
//   dp   : decimal point, passed through to seg[7]
//   seg  : [6:0] gfedcba, [7] dp, [8] tied 0
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [8:0] seg
);
    always_comb begin
        seg    = '0;
        seg[7] = dp;
        if (code < 4'd10) begin
            seg[6:0] = SEG_TABLE[code];
        end
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver.
// Scans NUM_DIG digits onto one 9-bit segment bus, one slot of SLOT_CYC
// cycles per digit, with the first GAP_CYC cycles of each slot dark.
// Input digits are double-buffered (shadow -> active at frame boundary)
// so an update never tears a frame.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : seg7_scan_driver_if.slave (digits/dp/strobe in, segments/selects out)
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking,
// evaluated on the active buffer.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIG  = 4,
    parameter int SLOT_CYC = 12000,
    parameter int GAP_CYC  = 16
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);
    localparam int CW    = cnt_width(SLOT_CYC);
    localparam int IW    = idx_width(NUM_DIG);
    localparam int SLOTS = 2 ** IW;

    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);

    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [IW-1:0]        idx_reg, idx_next;
    scan_state_t          state_reg, state_next;
    logic [4*NUM_DIG-1:0] shadow_dig_reg, active_dig_reg;
    logic [NUM_DIG-1:0]   shadow_dp_reg, active_dp_reg;
    logic [8:0]           seg_reg, seg_next;
    logic [NUM_DIG-1:0]   sel_reg, sel_next;
    logic                 frame_done_reg;

    logic                 frame_end;
    logic [3:0]           act_code [SLOTS];
    logic                 act_dp   [SLOTS];
    logic [NUM_DIG-1:0]   show_sel;
    logic [3:0]           mux_code;
    logic [8:0]           dec_seg;

    assign frame_end = (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);

    // Active buffer viewed as a power-of-two array so idx_reg indexes it
    // without width adjustment; padding entries are never selected.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
            if (gi < NUM_DIG) begin : g_real
                assign act_code[gi] = active_dig_reg[4*gi +: 4];
                assign act_dp[gi]   = active_dp_reg[gi];
            end else begin : g_pad
                assign act_code[gi] = 4'd0;
                assign act_dp[gi]   = 1'b0;
            end
        end
        for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_sel
            assign show_sel[gi] = (idx_reg != IW'(gi));
        end
    endgenerate

`ifdef SEG7_LZ_BLANK_EN
    logic [SLOTS-1:0] blank_vec;
    logic             lz_lead;

    // Walk down from the top digit while digits are zero with no dp;
    // digit 0 is never blanked.
    always_comb begin
        blank_vec = '0;
        lz_lead   = 1'b1;
        for (int i = NUM_DIG - 1; i >= 1; i--) begin
            if (lz_lead && (act_code[i] == 4'd0) && !act_dp[i]) begin
                blank_vec[i] = 1'b1;
            end else begin
                lz_lead = 1'b0;
            end
        end
    end

    assign mux_code = blank_vec[idx_reg] ? BLANK_CODE : act_code[idx_reg];
`else
    assign mux_code = act_code[idx_reg];
`endif

    bcd_to_seg7 u_dec (
        .code (mux_code),
        .dp   (act_dp[idx_reg]),
        .seg  (dec_seg)
    );

    // Slot timing and GAP/SHOW sequencing.
    always_comb begin
        cnt_next   = cnt_reg + 1'b1;
        idx_next   = idx_reg;
        state_next = state_reg;
        if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            state_next = GAP;
        end else if (cnt_reg == GAP_LAST) begin
            state_next = SHOW;
        end
    end

    // Pin values for the next cycle; pins lag state/idx by one cycle.
    always_comb begin
        seg_next = '0;
        sel_next = '1;
        if (state_reg == SHOW) begin
            seg_next = dec_seg;
            sel_next = show_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            state_reg      <= GAP;
            shadow_dig_reg <= '0;
            shadow_dp_reg  <= '0;
            active_dig_reg <= '0;
            active_dp_reg  <= '0;
            seg_reg        <= '0;
            sel_reg        <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            state_reg <= state_next;
            if (bus.upd_stb) begin
                shadow_dig_reg <= bus.digits_in;
                shadow_dp_reg  <= bus.dp_in;
            end
            // A strobe on the boundary cycle bypasses the shadow so the
            // newest value reaches the very next frame.
            if (frame_end) begin
                active_dig_reg <= bus.upd_stb ? bus.digits_in : shadow_dig_reg;
                active_dp_reg  <= bus.upd_stb ? bus.dp_in     : shadow_dp_reg;
            end
            seg_reg        <= seg_next;
            sel_reg        <= sel_next;
            // High in the first GAP cycle of slot 0 of the new frame.
            frame_done_reg <= frame_end;
        end
    end

    assign bus.seg_out    = seg_reg;
    assign bus.dig_sel    = sel_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NUM_DIG=4, SLOT_CYC=8, GAP_CYC=2).
// The stimulus process predicts the pins after each clock edge from a
// frame/slot arithmetic model and queues them; the monitor pops one entry
// per edge and compares.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int GAPC  = 2;
    localparam int FRAME = ND * SLOT;
`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct packed {
        logic [8:0]  seg;
        logic [3:0]  sel;
        logic        fd;
        logic [31:0] n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   frames_seen = 0;
    exp_t exp_q [$];

    // Reference model state
    int          n = 0;
    logic [15:0] pend_d = '0, act_d = '0;
    logic [3:0]  pend_dp = '0, act_dp = '0;

    seg7_scan_driver_if #(.NUM_DIG(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIG  (ND),
        .SLOT_CYC (SLOT),
        .GAP_CYC  (GAPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Which digits leading-zero blanking suppresses (all zero when disabled)
    function automatic logic [3:0] lz_mask(input logic [15:0] d, input logic [3:0] dp);
        logic [3:0] m;
        m = '0;
        for (int i = ND - 1; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'd0 || dp[i]) break;
            m[i] = LZ;
        end
        return m;
    endfunction

    function automatic logic [8:0] exp_seg(input logic [15:0] d, input logic [3:0] dp, input int k);
        logic [3:0] m;
        logic [8:0] s;
        m = lz_mask(d, dp);
        s = '0;
        s[7] = dp[k];
        s[6:0] = m[k] ? 7'h00 : seg_of(d[4*k +: 4]);
        return s;
    endfunction

    // Called right after each rising edge: predict the pins for this cycle.
    task automatic model_edge();
        exp_t        e;
        logic [15:0] seen_d;
        logic [3:0]  seen_dp;
        int          p, dig;
        e.seg = '0;
        e.sel = 4'hF;
        e.fd  = 1'b0;
        if (rst) begin
            n = 0;
            pend_d = '0; pend_dp = '0;
            act_d  = '0; act_dp  = '0;
        end else begin
            seen_d  = act_d;
            seen_dp = act_dp;
            n++;
            if (bus.upd_stb) begin
                pend_d  = bus.digits_in;
                pend_dp = bus.dp_in;
            end
            if (n % FRAME == 0) begin
                act_d  = pend_d;
                act_dp = pend_dp;
            end
            p   = n - 1;
            dig = (p / SLOT) % ND;
            e.fd = (n % FRAME == 0);
            if (p % SLOT >= GAPC) begin
                e.sel = ~(4'b0001 << dig);
                e.seg = exp_seg(seen_d, seen_dp, dig);
            end
        end
        e.n = n;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        if (r && !rst) begin
            rst = 1'b1;
            #1;
            tests++;
            if (bus.seg_out !== 9'h000 || bus.dig_sel !== 4'hF || bus.frame_done !== 1'b0) begin
                fails++;
                $display("FAIL async_dark: seg=%h sel=%b fd=%b required seg=000 sel=1111 fd=0",
                         bus.seg_out, bus.dig_sel, bus.frame_done);
            end
        end
        rst = r;
        bus.upd_stb   = s;
        bus.digits_in = d;
        bus.dp_in     = p;
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'($urandom()), 4'($urandom()));
    endtask

    task automatic strobe(input logic [15:0] d, input logic [3:0] p);
        $display("[TB] upd_stb digits=%h dp=%b at edge %0d", d, p, n + 1);
        step(1'b0, 1'b1, d, p);
    endtask

    task automatic reset_for(input int k);
        $display("[TB] reset for %0d cycles at edge %0d", k, n + 1);
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, '0, '0);
    endtask

    // Idle until the next edge lands at frame position pos (0 = boundary).
    task automatic go_to(input int pos);
        for (int i = 0; i < FRAME && ((n + 1) % FRAME) != pos; i++) idle(1);
    endtask

    // Monitor: one comparison per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.seg_out !== e.seg || bus.dig_sel !== e.sel || bus.frame_done !== e.fd) begin
                    fails++;
                    $display("FAIL pins edge=%0d: seg=%h sel=%b fd=%b required seg=%h sel=%b fd=%b",
                             e.n, bus.seg_out, bus.dig_sel, bus.frame_done, e.seg, e.sel, e.fd);
                end
                if (e.fd) begin
                    frames_seen++;
                    $display("[TB] frame %0d complete at edge %0d", frames_seen, e.n);
                end
            end
        end
    end

    initial begin
        bus.upd_stb   = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;

        reset_for(5);
        idle(10);
        strobe(16'h4321, 4'b0000);
        idle(70);
        go_to(10);
        strobe(16'h9999, 4'b0000);
        idle(70);
        go_to(0);
        strobe(16'h0A05, 4'b0010);
        idle(40);
        go_to(21);
        reset_for(3);
        idle(40);
        go_to(5);
        strobe(16'h1111, 4'b0000);
        go_to(20);
        strobe(16'h2222, 4'b0000);
        idle(70);

        for (int t = 0; t < 30; t++) begin
            logic [15:0] d;
            logic [3:0]  p;
            idle($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) begin
                reset_for($urandom_range(1, 3));
            end else begin
                d = 16'($urandom());
                // encourage leading zeros and codes in 0..9
                if ($urandom_range(0, 1) == 1) d = d & 16'h0777;
                if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
                p = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
                if ($urandom_range(0, 3) == 0) go_to(0);
                strobe(d, p);
            end
        end
        idle(70);

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 8421 BCD counter stages.
- Takes NUM_DIG packed BCD digits plus decimal points and time-multiplexes them onto one shared 9-bit segment bus with active-low digit selects.
- Double-buffers the input so a counter update never tears mid-frame.
- Inserts a dark gap between digit slots to suppress ghosting.

Parameters:
- NUM_DIG, 4, number of digits scanned, legal range 1..8.
- SLOT_CYC, 12000, clk cycles per digit slot (1 ms at 12 MHz), minimum 4.
- GAP_CYC, 16, dark cycles at the start of each slot, must be less than SLOT_CYC.

Ports:
- clk  in  1  system clock, 12 MHz
- rst  in  1  asynchronous, active-high reset
- digits_in  in  4*NUM_DIG  packed BCD, digit 0 in bits [3:0], digit 0 is rightmost
- dp_in  in  NUM_DIG  decimal point per digit, 1 = lit
- upd_stb  in  1  one-cycle strobe that captures digits_in/dp_in into the shadow buffer
- seg_out  out  9  [6:0] = a..g, [7] = dp, [8] = 0; active-high
- dig_sel  out  NUM_DIG  active-low digit enables, at most one bit low
- frame_done  out  1  one-cycle pulse when the last slot of a frame ends

Behaviour:
- Reset (async, rst=1):
  - slot counter cnt=0, digit index idx=0, state=GAP.
  - shadow and active buffers cleared to 0.
  - seg_out=0, dig_sel=all ones, frame_done=0.
- Reset release mid-frame restarts at slot 0 in GAP. No partial output is allowed.
- Slot counter: cnt counts 0..SLOT_CYC-1 and wraps. At cnt==SLOT_CYC-1, idx advances. idx==NUM_DIG-1 wraps to 0.
- State machine (two states):
  - GAP: cnt < GAP_CYC.
  - SHOW: GAP_CYC ≤ cnt ≤ SLOT_CYC-1.
  - GAP→SHOW at cnt==GAP_CYC-1.
  - SHOW→GAP at cnt==SLOT_CYC-1.
- Outputs are registered, with 1-cycle latency from state/idx to the pins:
  - During GAP: dig_sel = all ones, seg_out = 0.
  - During SHOW: dig_sel[idx]=0, others 1; seg_out = decode(active[idx]) with bit7 = active_dp[idx].
- Decode table (a..g, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 decode to 00 (blank segments); dp still honoured.
- Buffering:
  - upd_stb writes shadow on the next edge.
  - The active buffer loads from shadow at the frame boundary (cnt==SLOT_CYC-1 and idx==NUM_DIG-1).
  - If upd_stb coincides with the frame boundary, active loads digits_in/dp_in directly (new value wins), and shadow also takes it.
  - Multiple upd_stb within a frame: the last one wins.
- frame_done: registered. Asserted for exactly one cycle, aligned with the first GAP cycle of slot 0 of the next frame.
- NUM_DIG=1: idx is constant 0, and frame_done pulses every slot.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking is enabled.
  - Scanning from digit NUM_DIG-1 downward, every digit equal to 0 before the first nonzero digit shows seg_out[6:0]=0.
  - Digit 0 is never blanked.
  - dp_in of a blanked digit stops the blanking at that digit and below.
  - Blanking is evaluated on the active buffer only.
- Undefined: all digits are decoded literally, and the blanking logic is absent from the netlist.

Decomposition:
- Package seg7_pkg holds:
  - the 10-entry segment constant table and the blank code;
  - the two-state enum (GAP, SHOW);
  - localparam widths: cnt width = $clog2(SLOT_CYC), idx width = $clog2(NUM_DIG) with a minimum of 1.
- One sub-module, bcd_to_seg7: purely combinational, 4-bit code + dp in, 9-bit segments out. Instantiated once on the muxed digit.

Test Plan (NUM_DIG=4, SLOT_CYC=8, GAP_CYC=2):
1. Reset held 5 cycles, then released:
   - seg_out=000 and dig_sel=1111 throughout reset.
   - The first SHOW cycle (3rd cycle after release, +1 latency) shows dig_sel=1110.
2. upd_stb with digits_in=16'h4321, dp_in=0:
   - The following frame shows 06, 5B, 4F, 66 on dig_sel 1110, 1101, 1011, 0111.
   - Each slot has 2 dark cycles; frame_done pulses once every 32 cycles.
3. upd_stb mid-frame with 16'h9999:
   - The current frame still shows 4321.
   - The next frame shows 6F on all four digits.
4. upd_stb on the frame-boundary cycle with 16'h0A05, dp_in=4'b0010:
   - The next frame shows 6D, 3F+dp=BF, 00, 3F.
   - With SEG7_LZ_BLANK_EN, digit 3 is 00 instead.
5. Assert rst during slot 2 SHOW:
   - Outputs go dark asynchronously; both buffers read 0.
   - After release, the scan restarts at digit 0 showing 3F.
6. Two upd_stb pulses in one frame (1111, then 2222):
   - The next frame shows 5B on all digits, with no frame showing 1111.
